proc_core_mc: RTL and testbench
===============================

Name: proc_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle 8-bit processor top.
- Fetches from an external combinational instruction memory, executes on an NREG x DATA_W register file, and moves data through valid/ready-handshaked in/out ports instead of free-running ones.
- Adds conditional branch, immediate load, halt, I/O back-pressure, reset and width/depth generalisation.
- Sits at the top of the processor subsystem; the instruction ROM is instantiated alongside it.

Parameters:
DATA_W, 8, datapath/register/port width (>=4)
NREG, 4, register count (power of 2, >=2); RA_W = clog2(NREG)
PC_W, 8, program counter width; address space 2^PC_W words
IMEM_W, 8, instruction word width; must be >= 4+2*RA_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock; asynchronous, active-low
imem_addr  out  PC_W  instruction address (= pc)
imem_data  in  IMEM_W  instruction word, combinational read of imem_addr
in_data  in  DATA_W  input port data
in_valid  in  1  input data available
in_ready  out  1  core accepting input
out_data  out  DATA_W  output port data (registered)
out_valid  out  1  out_data pending
out_ready  in  1  consumer accepts out_data
halted  out  1  core stopped in HALT

Behaviour:
- Decode: op=imem_data[IMEM_W-1 -: 4]; ra=next RA_W bits; rb=next RA_W bits; remaining low bits ignored.
- Ops (R[a] = register ra):
  - 0 NOP
  - 1 ADD R[a]=R[a]+R[b]; 2 SUB R[a]=R[a]-R[b]; 3 AND; 4 OR; 5 XOR
  - 6 SHL R[a]=R[a]<<1; 7 MOV R[a]=R[b]
  - 8 IN; 9 OUT; A BZ; B LDI; C HALT; D-F NOP (see optional feature)
- All arithmetic is mod 2^DATA_W; carries are discarded.
- FSM states: FETCH, EXEC, IMM, WAIT_IN, WAIT_OUT, HALT.
  - FETCH: ir<=imem_data -> EXEC.
  - EXEC, ALU op / MOV / NOP: write R[a], pc<=pc+1 -> FETCH. Two cycles per instruction.
  - BZ: if R[a]==0, pc<=R[b][PC_W-1:0] (zero-extended if DATA_W<PC_W); else pc<=pc+1 -> FETCH.
  - LDI: pc<=pc+1 -> IMM. IMM: R[a]<=imem_data zero-extended/truncated to DATA_W, pc<=pc+1 -> FETCH. Three cycles total.
  - IN: -> WAIT_IN. WAIT_IN: in_ready=1; on in_valid&in_ready, R[a]<=in_data, pc<=pc+1 -> FETCH. Stalls indefinitely otherwise.
  - OUT: if !out_valid or out_ready in the same cycle: out_data<=R[a], out_valid<=1, pc<=pc+1 -> FETCH. Else -> WAIT_OUT, which retries the same condition each cycle.
  - HALT: -> HALT; halted=1. Only reset exits.
- out_valid clears on out_valid&out_ready unless a new OUT loads in that same cycle, in which case it stays 1 with the new data.
- in_ready is 1 only in WAIT_IN; in_valid is ignored elsewhere.
- pc wraps 2^PC_W-1 -> 0 silently.
- ra==rb is legal: SUB gives 0, XOR gives 0, ADD doubles.
- Reset (asynchronous, any state including mid-stall): pc=0, state=FETCH, all registers=0, ir=0, out_data=0, out_valid=0, in_ready=0, halted=0. Any pending output is dropped.

Optional Feature:
PROC_CARRY_EN
- Defined:
  - 1-bit carry flag C, reset 0.
  - ADD and SHL set C to carry-out; SUB sets C to borrow (R[a]<R[b]).
  - Other ops leave C unchanged.
  - New op D ADC: R[a]=R[a]+R[b]+C, updates C.
  - New op E BC: branch like BZ but taken when C==1.
- Undefined: no flag logic; D and E execute as NOP (pc+1).

Test Plan:
- Reset then ROM {B0 (LDI r0), 05, B4 (LDI r1), 03, 14 (ADD r1,r0), 94 (OUT r1), C0}, out_ready=1 -> out_data=0x08 with out_valid pulse, then halted=1, pc=6. Assert cycle counts: LDI=3, ADD=2.
- IN r2 with in_valid low for 5 cycles then in_data=0xA5 -> in_ready high exactly 6 cycles; R2=0xA5; single transfer.
- Two back-to-back OUTs with out_ready=0 -> first stays on out_data, core holds in WAIT_OUT; raising out_ready for 1 cycle -> second value loads, out_valid stays 1.
- BZ loop: r0=3, r1=loop address, decrement via SUB until zero -> branch taken 0 times while r0!=0, falls through after 3 iterations; pc=0xFF+1 wraps to 0.
- Assert rst_n low mid WAIT_IN and with out_valid=1 -> all outputs 0 immediately (asynchronous), fetch restarts at pc=0.
- PROC_CARRY_EN: r0=0xFF, r1=0x01, ADD -> r0=0, C=1; ADC r2(0),r2 -> 1; BC taken. Without macro, op D/E -> no register change, pc+1.

Source files
------------

// File: rtl/proc_core_mc.sv
// -----------------------------------------------------------------------------
// proc_core_mc -- parametrised multi-cycle processor core.
//
// Fetches from an external combinational instruction memory, executes on an
// NREG x DATA_W register file, and exchanges data through valid/ready
// handshaked input and output ports. A halted core stays stopped until reset.
//
// Optional feature macro: PROC_CARRY_EN
//   defined   : carry flag, ADD/SUB/SHL update it, op D = ADC, op E = BC
//   undefined : no flag logic, ops D and E behave as NOP
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   imem_addr  out  instruction address (the program counter)
//   imem_data  in   instruction word read combinationally at imem_addr
//   in_data    in   input port data
//   in_valid   in   input data available
//   in_ready   out  core waiting for input (only while in WAIT_IN)
//   out_data   out  registered output port data
//   out_valid  out  out_data pending
//   out_ready  in   consumer accepts out_data
//   halted     out  core stopped by HALT
// -----------------------------------------------------------------------------
module proc_core_mc #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int PC_W   = 8,
    parameter int IMEM_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [IMEM_W-1:0] imem_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
);
    localparam int RA_W = $clog2(NREG);
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_LDI  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;
`ifdef PROC_CARRY_EN
    localparam logic [3:0] OP_ADC  = 4'hD;
    localparam logic [3:0] OP_BC   = 4'hE;
`endif

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_EXEC     = 3'd1,
        ST_IMM      = 3'd2,
        ST_WAIT_IN  = 3'd3,
        ST_WAIT_OUT = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [PC_W-1:0]   pc_r, pc_nxt_s, pc_inc_s, br_tgt_s;
    logic [IMEM_W-1:0] ir_r;
    logic [DATA_W-1:0] regs_r [NREG];
    logic [3:0]        op_s;
    logic [RA_W-1:0]   ra_s, rb_s;
    logic [DATA_W-1:0] a_val_s, b_val_s, imm_s, rf_wd_s, out_data_r;
    logic              ir_ld_s, rf_we_s, out_ld_s;
    logic              out_valid_r, in_ready_r, halted_r;
`ifdef PROC_CARRY_EN
    logic              carry_r, carry_nxt_s;
`endif

    assign op_s     = ir_r[IMEM_W-1 -: 4];
    assign ra_s     = ir_r[IMEM_W-5 -: RA_W];
    assign rb_s     = ir_r[IMEM_W-5-RA_W -: RA_W];
    assign a_val_s  = regs_r[ra_s];
    assign b_val_s  = regs_r[rb_s];
    assign pc_inc_s = pc_r + PC_ONE;

    // Immediate word and branch target are zero-extended or truncated to fit.
    generate
        if (DATA_W > IMEM_W) begin : g_imm_ext
            assign imm_s = {{(DATA_W-IMEM_W){1'b0}}, imem_data};
        end else begin : g_imm_trunc
            assign imm_s = imem_data[DATA_W-1:0];
        end
        if (PC_W > DATA_W) begin : g_tgt_ext
            assign br_tgt_s = {{(PC_W-DATA_W){1'b0}}, b_val_s};
        end else begin : g_tgt_trunc
            assign br_tgt_s = b_val_s[PC_W-1:0];
        end
    endgenerate

    // Next-state, program counter and datapath control decode.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ir_ld_s     = 1'b0;
        rf_we_s     = 1'b0;
        rf_wd_s     = {DATA_W{1'b0}};
        out_ld_s    = 1'b0;
`ifdef PROC_CARRY_EN
        carry_nxt_s = carry_r;
`endif
        case (state_r)
            ST_FETCH: begin
                ir_ld_s     = 1'b1;
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                // Most ops advance and return to fetch; stalls override below.
                pc_nxt_s    = pc_inc_s;
                state_nxt_s = ST_FETCH;
                case (op_s)
                    OP_ADD: begin
                        rf_we_s = 1'b1;
`ifdef PROC_CARRY_EN
                        {carry_nxt_s, rf_wd_s} = {1'b0, a_val_s} + {1'b0, b_val_s};
`else
                        rf_wd_s = a_val_s + b_val_s;
`endif
                    end
                    OP_SUB: begin
                        rf_we_s = 1'b1;
                        rf_wd_s = a_val_s - b_val_s;
`ifdef PROC_CARRY_EN
                        carry_nxt_s = (a_val_s < b_val_s);
`endif
                    end
                    OP_AND: begin
                        rf_we_s = 1'b1;
                        rf_wd_s = a_val_s & b_val_s;
                    end
                    OP_OR: begin
                        rf_we_s = 1'b1;
                        rf_wd_s = a_val_s | b_val_s;
                    end
                    OP_XOR: begin
                        rf_we_s = 1'b1;
                        rf_wd_s = a_val_s ^ b_val_s;
                    end
                    OP_SHL: begin
                        rf_we_s = 1'b1;
                        rf_wd_s = {a_val_s[DATA_W-2:0], 1'b0};
`ifdef PROC_CARRY_EN
                        carry_nxt_s = a_val_s[DATA_W-1];
`endif
                    end
                    OP_MOV: begin
                        rf_we_s = 1'b1;
                        rf_wd_s = b_val_s;
                    end
                    OP_IN: begin
                        pc_nxt_s    = pc_r;
                        state_nxt_s = ST_WAIT_IN;
                    end
                    OP_OUT: begin
                        // Load now if the output slot is free or draining this cycle.
                        if (!out_valid_r || out_ready) begin
                            out_ld_s = 1'b1;
                        end else begin
                            pc_nxt_s    = pc_r;
                            state_nxt_s = ST_WAIT_OUT;
                        end
                    end
                    OP_BZ: begin
                        if (a_val_s == {DATA_W{1'b0}}) begin
                            pc_nxt_s = br_tgt_s;
                        end else begin
                            pc_nxt_s = pc_inc_s;
                        end
                    end
                    OP_LDI: begin
                        state_nxt_s = ST_IMM;
                    end
                    OP_HALT: begin
                        pc_nxt_s    = pc_r;
                        state_nxt_s = ST_HALT;
                    end
`ifdef PROC_CARRY_EN
                    OP_ADC: begin
                        rf_we_s = 1'b1;
                        {carry_nxt_s, rf_wd_s} = {1'b0, a_val_s} + {1'b0, b_val_s}
                                               + {{DATA_W{1'b0}}, carry_r};
                    end
                    OP_BC: begin
                        if (carry_r) begin
                            pc_nxt_s = br_tgt_s;
                        end else begin
                            pc_nxt_s = pc_inc_s;
                        end
                    end
`endif
                    default: rf_we_s = 1'b0;
                endcase
            end
            ST_IMM: begin
                rf_we_s     = 1'b1;
                rf_wd_s     = imm_s;
                pc_nxt_s    = pc_inc_s;
                state_nxt_s = ST_FETCH;
            end
            ST_WAIT_IN: begin
                if (in_valid) begin
                    rf_we_s     = 1'b1;
                    rf_wd_s     = in_data;
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_WAIT_IN;
                end
            end
            ST_WAIT_OUT: begin
                if (!out_valid_r || out_ready) begin
                    out_ld_s    = 1'b1;
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_WAIT_OUT;
                end
            end
            ST_HALT:  state_nxt_s = ST_HALT;
            default:  state_nxt_s = ST_FETCH;
        endcase
    end

    // Control state, pc, instruction register and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            pc_r       <= {PC_W{1'b0}};
            ir_r       <= {IMEM_W{1'b0}};
            in_ready_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            if (ir_ld_s) begin
                ir_r <= imem_data;
            end
            // Flags follow the state being entered so they line up with it.
            in_ready_r <= (state_nxt_s == ST_WAIT_IN);
            halted_r   <= (state_nxt_s == ST_HALT);
        end
    end

    // Register file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (rf_we_s) begin
            regs_r[ra_s] <= rf_wd_s;
        end
    end

    // Output port: a new load wins over a simultaneous drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (out_ld_s) begin
            out_data_r  <= a_val_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef PROC_CARRY_EN
    // Carry flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_r <= 1'b0;
        end else begin
            carry_r <= carry_nxt_s;
        end
    end
`endif

    assign imem_addr = pc_r;
    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_proc_core_mc.sv
// -----------------------------------------------------------------------------
// tb_proc_core_mc -- scoreboard bench for proc_core_mc (default parameters).
// Stimulus loads small hand-assembled programs into a model ROM and pushes
// the expected output-port values; an independent monitor pops and compares
// them on every out_valid & out_ready handshake.
// -----------------------------------------------------------------------------
module tb_proc_core_mc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] imem_addr, imem_data, in_data, out_data;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, halted;

    logic [7:0] rom [256];
    logic [7:0] prog_q [$];
    logic [7:0] exp_q [$];
    int n_pass = 0;
    int n_total = 0;
    int in_rdy_cnt = 0;
    int xfer_cnt = 0;

    assign imem_data = rom[imem_addr];

    proc_core_mc #(.DATA_W(8), .NREG(4), .PC_W(8), .IMEM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Output scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL out_extra: got %0h expected nothing", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // Input handshake counters.
    always @(negedge clk) begin
        if (in_ready) in_rdy_cnt++;
        if (in_ready && in_valid) xfer_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < prog_q.size(); i++) rom[i] = prog_q[i];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        load_prog();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_to_addr(input logic [7:0] target, input int max_cyc, output int cyc);
        cyc = 0;
        while (imem_addr !== target && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check("reach_addr", imem_addr, target);
    endtask

    task automatic run_to_halt(input int max_cyc);
        int cyc = 0;
        while (halted !== 1'b1 && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check("halted", halted, 1'b1);
    endtask

    task automatic run_to_in_ready(input int max_cyc);
        int cyc = 0;
        while (in_ready !== 1'b1 && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check("in_ready_seen", in_ready, 1'b1);
    endtask

    initial begin
        int cyc;
        int base_rdy;
        int base_xfer;
        in_data = 8'h00;

        // Test 1: LDI/LDI/ADD/OUT/HALT with timing of LDI and ADD.
        prog_q = '{8'hB0, 8'h05, 8'hB4, 8'h03, 8'h14, 8'h94, 8'hC0};
        out_ready = 1'b1;
        rst_n = 1'b0;
        load_prog();
        step();
        check("rst_pc", imem_addr, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_halted", halted, 1'b0);
        step();
        rst_n = 1'b1;
        exp_q.push_back(8'h08);
        run_to_addr(8'd2, 20, cyc);
        check("ldi_cycles", cyc, 3);
        run_to_addr(8'd4, 20, cyc);
        check("ldi2_cycles", cyc, 3);
        run_to_addr(8'd5, 20, cyc);
        check("add_cycles", cyc, 2);
        run_to_halt(30);
        check("halt_pc", imem_addr, 8'd6);
        check("pulse_done", out_valid, 1'b0);

        // Test 2: IN stalls until in_valid; exactly one transfer.
        prog_q = '{8'h88, 8'h98, 8'hC0};
        do_reset();
        exp_q.push_back(8'hA5);
        run_to_in_ready(20);
        base_rdy = in_rdy_cnt;
        base_xfer = xfer_cnt;
        repeat (5) step();
        in_valid = 1'b1;
        in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        in_data = 8'h00;
        step();
        check("in_ready_cycles", in_rdy_cnt - base_rdy, 6);
        check("in_xfers", xfer_cnt - base_xfer, 1);
        run_to_halt(30);

        // Test 3: back-to-back OUT under back-pressure.
        prog_q = '{8'hB0, 8'h11, 8'hB4, 8'h22, 8'h90, 8'h94, 8'hC0};
        out_ready = 1'b0;
        do_reset();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        run_to_addr(8'd5, 30, cyc);
        repeat (4) step();
        check("bp_out_data", out_data, 8'h11);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_pc_held", imem_addr, 8'd5);
        check("bp_not_halted", halted, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_second_data", out_data, 8'h22);
        check("bp_valid_kept", out_valid, 1'b1);
        step();
        out_ready = 1'b1;
        run_to_halt(30);
        check("bp_drained", out_valid, 1'b0);

        // Test 4: BZ countdown loop, exit to 0xFD, then pc wraps to 0.
        prog_q = '{8'hB0, 8'h03, 8'hB4, 8'h08, 8'hBC, 8'hFD, 8'h00, 8'h00,
                   8'hB8, 8'h01, 8'h22, 8'h90, 8'hA3, 8'hB8, 8'h00, 8'hA9};
        do_reset();
        rom[8'hFD] = 8'h94;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        run_to_addr(8'hFF, 400, cyc);
        run_to_addr(8'h00, 10, cyc);
        check("wrap_cycles", cyc, 2);

        // Test 5: asynchronous reset during WAIT_IN with output pending.
        prog_q = '{8'hB0, 8'h5A, 8'h90, 8'h84, 8'hC0};
        out_ready = 1'b0;
        do_reset();
        run_to_in_ready(30);
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_data", out_data, 8'h5A);
        rst_n = 1'b0;
        #2;
        check("async_in_ready", in_ready, 1'b0);
        check("async_out_valid", out_valid, 1'b0);
        check("async_out_data", out_data, 8'h00);
        check("async_pc", imem_addr, 8'h00);
        step();
        rst_n = 1'b1;
        check("restart_pc", imem_addr, 8'h00);
        repeat (3) step();
        check("restart_ldi", imem_addr, 8'd2);
        out_ready = 1'b1;
        exp_q.push_back(8'h5A);
        run_to_in_ready(20);
        step();

`ifdef PROC_CARRY_EN
        // Test 6: carry out of ADD, BC taken, ADC consumes carry.
        prog_q = '{8'hB0, 8'hFF, 8'hB4, 8'h01, 8'hBC, 8'h0A, 8'h11, 8'h90,
                   8'hE3, 8'hC0, 8'hDA, 8'h98, 8'hC0};
        do_reset();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        run_to_halt(80);
        check("carry_halt_pc", imem_addr, 8'd12);
`else
        // Test 6: ops D/E are NOPs; logic ops, SHL, MOV and ra==rb cases.
        prog_q = '{8'hB0, 8'hC3, 8'hB4, 8'h5A, 8'hD1, 8'hE1, 8'h90, 8'h78,
                   8'h39, 8'h98, 8'h78, 8'h49, 8'h98, 8'h78, 8'h59, 8'h98,
                   8'h60, 8'h90, 8'h10, 8'h90, 8'h55, 8'h94, 8'hC0};
        do_reset();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'hDB);
        exp_q.push_back(8'h99);
        exp_q.push_back(8'h86);
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h00);
        run_to_addr(8'd6, 20, cyc);
        check("nop_de_cycles", cyc, 10);
        run_to_halt(120);
        check("alu_halt_pc", imem_addr, 8'd22);
`endif
        repeat (3) step();
        check("out_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
